// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the MEM-stage data-memory access block:
// bus widths, micro-op codes, FSM state encoding, byte-select constants,
// and small decode helpers used by both the top and the lane extractor.
// No ports (package).
package mem_access_pkg;

  typedef logic [31:0] reg_t;      // RegBus
  typedef logic [4:0]  regaddr_t;  // RegAddrBus
  typedef logic [7:0]  aluop_t;    // AluOpBus

  localparam logic     RST_ENABLE   = 1'b0;
  localparam reg_t     ZERO_WORD    = 32'h0000_0000;
  localparam regaddr_t NOP_REG_ADDR = 5'b00000;

  localparam aluop_t EXE_NOP_OP = 8'b0000_0000;
  localparam aluop_t EXE_OR_OP  = 8'b0010_0101;
  localparam aluop_t EXE_LB_OP  = 8'b1110_0000;
  localparam aluop_t EXE_LH_OP  = 8'b1110_0001;
  localparam aluop_t EXE_LW_OP  = 8'b1110_0011;
  localparam aluop_t EXE_LBU_OP = 8'b1110_0100;
  localparam aluop_t EXE_LHU_OP = 8'b1110_0101;
  localparam aluop_t EXE_SB_OP  = 8'b1110_1000;
  localparam aluop_t EXE_SH_OP  = 8'b1110_1001;
  localparam aluop_t EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  function automatic logic is_load(aluop_t op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(aluop_t op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_byte(aluop_t op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_SB_OP);
  endfunction

  function automatic logic is_half(aluop_t op);
    return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
  endfunction

  function automatic logic is_word(aluop_t op);
    return (op == EXE_LW_OP) || (op == EXE_SW_OP);
  endfunction

  // Byte enables; lane 0 is the MSB byte in big-endian mode.
  function automatic logic [3:0] calc_sel(aluop_t op, logic [1:0] a, logic be);
    logic [3:0] s;
    if (is_byte(op))      s = be ? (4'b1000 >> a) : (4'b0001 << a);
    else if (is_half(op)) s = (a[1] ^ be) ? 4'b1100 : 4'b0011;
    else                  s = SEL_WORD;
    return s;
  endfunction

  // Store data replicated across every lane so any sel picks the right bytes.
  function automatic reg_t store_data(aluop_t op, reg_t r);
    reg_t d;
    if (is_byte(op))      d = {4{r[7:0]}};
    else if (is_half(op)) d = {2{r[15:0]}};
    else                  d = r;
    return d;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if
// Data-memory request/acknowledge bus.
//   mem_ce_o   request strobe (held until ack/abort)
//   mem_we_o   1 = write
//   mem_addr_o word-aligned address
//   mem_sel_o  byte enables
//   mem_data_o store data (lane replicated)
//   mem_data_i read data, valid with mem_ack_i
//   mem_ack_i  one-cycle completion strobe
// master: the MEM stage; slave: the memory.
interface mem_access_if;
  import mem_access_pkg::*;

  logic       mem_ce_o;
  logic       mem_we_o;
  reg_t       mem_addr_o;
  logic [3:0] mem_sel_o;
  reg_t       mem_data_o;
  reg_t       mem_data_i;
  logic       mem_ack_i;

  modport master (
    output mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/mem_access_lane_ext.sv
// mem_lane_ext
// Combinational load-lane extractor: picks the byte/halfword addressed by
// i_addr out of a read word and sign- or zero-extends it per i_aluop.
// Ports:
//   i_rdata  read word captured from the bus
//   i_addr   low two bits of the effective address
//   i_aluop  load micro-op (non-load ops return i_rdata unchanged)
//   o_ext    extended load value
module mem_lane_ext
  import mem_access_pkg::*;
#(
  parameter logic BIG_ENDIAN = 1'b1
) (
  input  reg_t       i_rdata,
  input  logic [1:0] i_addr,
  input  aluop_t     i_aluop,
  output reg_t       o_ext
);

  logic [1:0]  w_bidx;
  logic        w_hhi;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Index of the byte counted from the LSB end of the word.
  assign w_bidx = BIG_ENDIAN ? ~i_addr : i_addr;
  assign w_hhi  = BIG_ENDIAN ? ~i_addr[1] : i_addr[1];
  assign w_half = w_hhi ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    w_byte = i_rdata[7:0];
    case (w_bidx)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  always_comb begin
    o_ext = i_rdata;
    case (i_aluop)
      EXE_LB_OP:  o_ext = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: o_ext = {24'h000000, w_byte};
      EXE_LH_OP:  o_ext = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: o_ext = {16'h0000, w_half};
      default:    o_ext = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
// MEM-stage load/store engine. Converts an EX/MEM memory micro-op into a
// registered request/ack bus transaction, stalls the pipeline until it
// completes, and presents the write-back triple to MEM/WB. Non-memory ops
// pass straight through combinationally.
// Parameters: BIG_ENDIAN (lane 0 = data[31:24] when 1), ACK_TIMEOUT
// (REQ cycles before abort, 0 disables the watchdog).
// Optional feature macro: MEM_ALIGN_CHECK_EN -- misaligned half/word
// accesses are rejected without a bus cycle and flagged on mem_err_o.
// Ports:
//   clk, rst (sync, active-low)
//   wd_i/wreg_i/wdata_i  write-back triple from EX/MEM
//   aluop_i, mem_addr_i, reg2_i  micro-op, effective address, store data
//   wd_o/wreg_o/wdata_o  write-back triple to MEM/WB
//   bus (mem_access_if.master) data-memory bus
//   stallreq_o  stall request, mem_err_o one-cycle error pulse
module mem_access
  import mem_access_pkg::*;
#(
  parameter logic        BIG_ENDIAN  = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  regaddr_t wd_i,
  input  logic     wreg_i,
  input  reg_t     wdata_i,
  input  aluop_t   aluop_i,
  input  reg_t     mem_addr_i,
  input  reg_t     reg2_i,
  output regaddr_t wd_o,
  output logic     wreg_o,
  output reg_t     wdata_o,
  mem_access_if.master bus,
  output logic     stallreq_o,
  output logic     mem_err_o
);

  localparam logic        TO_EN    = (ACK_TIMEOUT != 0);
  localparam int unsigned TO_LIMIT = TO_EN ? ACK_TIMEOUT - 1 : 0;
  localparam logic [15:0] TO_LAST  = TO_LIMIT[15:0];

  mem_state_e r_state, w_next;
  logic       r_ce, r_we, r_err, r_abort;
  reg_t       r_addr, r_data, r_rdata;
  logic [3:0] r_sel;
  logic [15:0] r_cnt;

  logic w_is_mem, w_is_load, w_misalign, w_timeout;
  reg_t w_ext;

  assign w_is_load = is_load(aluop_i);
  assign w_is_mem  = w_is_load || is_store(aluop_i);
  // r_cnt counts completed REQ cycles, so the last allowed one is LIMIT-1.
  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (is_half(aluop_i) && mem_addr_i[0]) ||
                      (is_word(aluop_i) && (mem_addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  mem_lane_ext #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane_ext (
    .i_rdata (r_rdata),
    .i_addr  (mem_addr_i[1:0]),
    .i_aluop (aluop_i),
    .o_ext   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state <= MEM_IDLE;
      r_ce    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= ZERO_WORD;
      r_sel   <= SEL_NONE;
      r_data  <= ZERO_WORD;
      r_rdata <= ZERO_WORD;
      r_cnt   <= 16'h0000;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= 1'b0;
      case (r_state)
        MEM_IDLE: begin
          if (w_is_mem) begin
            if (w_misalign) begin
              r_err   <= 1'b1;
              r_abort <= 1'b1;
            end else begin
              r_ce    <= 1'b1;
              r_we    <= is_store(aluop_i);
              r_addr  <= {mem_addr_i[31:2], 2'b00};
              r_sel   <= calc_sel(aluop_i, mem_addr_i[1:0], BIG_ENDIAN);
              r_data  <= store_data(aluop_i, reg2_i);
              r_cnt   <= 16'h0000;
              r_abort <= 1'b0;
            end
          end
        end
        MEM_REQ: begin
          // Ack wins over a watchdog expiry in the same cycle.
          if (bus.mem_ack_i) begin
            r_rdata <= bus.mem_data_i;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= SEL_NONE;
          end else if (w_timeout) begin
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= SEL_NONE;
            r_err   <= 1'b1;
            r_abort <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'h0001;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    case (r_state)
      MEM_IDLE: if (w_is_mem) w_next = w_misalign ? MEM_DONE : MEM_REQ;
      MEM_REQ:  if (bus.mem_ack_i || w_timeout) w_next = MEM_DONE;
      default:  w_next = MEM_IDLE;
    endcase
    if (rst == RST_ENABLE) begin
      wd_o    = NOP_REG_ADDR;
      wreg_o  = 1'b0;
      wdata_o = ZERO_WORD;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_is_mem) begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
          end
        end
        MEM_REQ: begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
        end
        default: begin
          if (!w_is_load || r_abort) wreg_o  = 1'b0;
          else                       wdata_o = w_ext;
        end
      endcase
    end
  end

  assign bus.mem_ce_o   = r_ce;
  assign bus.mem_we_o   = r_we;
  assign bus.mem_addr_o = r_addr;
  assign bus.mem_sel_o  = r_sel;
  assign bus.mem_data_o = r_data;
  assign mem_err_o      = r_err;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed-vector bench with a transaction-level model of
// byte lanes, replication and extension; one negedge compare process.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic BE = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     rst;
  regaddr_t wd_i, wd_o;
  logic     wreg_i, wreg_o, stallreq_o, mem_err_o;
  reg_t     wdata_i, wdata_o, mem_addr_i, reg2_i;
  aluop_t   aluop_i;

  mem_access_if bus();

  mem_access #(.BIG_ENDIAN(BE), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .bus(bus),
    .stallreq_o(stallreq_o), .mem_err_o(mem_err_o)
  );

  typedef struct {
    bit v, c_addr, c_mdata, c_wdata;
    regaddr_t wd;
    logic wreg, stall, ce, we, err;
    logic [3:0] sel;
    reg_t addr, mdata, wdata;
  } exp_t;

  exp_t e;
  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e.v) begin
      chk("wd_o", wd_o, e.wd);
      chk("wreg_o", wreg_o, e.wreg);
      chk("stallreq_o", stallreq_o, e.stall);
      chk("mem_ce_o", bus.mem_ce_o, e.ce);
      chk("mem_we_o", bus.mem_we_o, e.we);
      chk("mem_sel_o", bus.mem_sel_o, e.sel);
      chk("mem_err_o", mem_err_o, e.err);
      if (e.c_addr)  chk("mem_addr_o", bus.mem_addr_o, e.addr);
      if (e.c_mdata) chk("mem_data_o", bus.mem_data_o, e.mdata);
      if (e.c_wdata) chk("wdata_o", wdata_o, e.wdata);
    end
  end

  // ---------------- model ----------------
  function automatic int m_size(aluop_t op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    return 4;
  endfunction

  function automatic bit m_is_st(aluop_t op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction

  function automatic bit m_is_ld(aluop_t op);
    return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
           op == EXE_LHU_OP || op == EXE_LW_OP;
  endfunction

  function automatic bit m_misaligned(aluop_t op, reg_t a);
`ifdef MEM_ALIGN_CHECK_EN
    return (m_size(op) == 2 && a[0]) || (m_size(op) == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_first(aluop_t op, reg_t a);
    if (m_size(op) == 1) return int'(a[1:0]);
    if (m_size(op) == 2) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [3:0] m_sel(aluop_t op, reg_t a);
    logic [3:0] s = 4'b0000;
    for (int k = 0; k < m_size(op); k++) begin
      int lane = m_first(op, a) + k;
      s[BE ? 3 - lane : lane] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [7:0] m_lane(reg_t d, int lane);
    return BE ? d[8*(3-lane) +: 8] : d[8*lane +: 8];
  endfunction

  function automatic reg_t m_ldval(aluop_t op, reg_t a, reg_t d);
    reg_t v = 32'h0;
    for (int k = 0; k < m_size(op); k++) begin
      reg_t b = {24'h0, m_lane(d, m_first(op, a) + k)};
      v = BE ? ((v << 8) | b) : (v | (b << (8*k)));
    end
    if (op == EXE_LB_OP && v[7])  v = v | 32'hFFFF_FF00;
    if (op == EXE_LH_OP && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic reg_t m_mdata(aluop_t op, reg_t r);
    reg_t d;
    for (int k = 0; k < 4; k++) d[8*k +: 8] = r[8*(k % m_size(op)) +: 8];
    return d;
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pass();
    e = '{default: 0};
    e.v = 1; e.wd = wd_i; e.wreg = wreg_i; e.c_wdata = 1; e.wdata = wdata_i;
  endtask

  task automatic pass_op(aluop_t op, regaddr_t wd, logic wr, reg_t wdat);
    tick();
    rst = 1'b1; aluop_i = op; wd_i = wd; wreg_i = wr; wdata_i = wdat;
    mem_addr_i = 32'h0000_0104; bus.mem_ack_i = 1'b0;
    set_pass();
  endtask

  task automatic run_mem(aluop_t op, reg_t a, reg_t r2, reg_t rd, int waits,
                         logic [3:0] sel_lit, reg_t val_lit, bit stray);
    logic [3:0] sel = m_sel(op, a);
    reg_t ldv = m_ldval(op, a, rd);
    bit mis = m_misaligned(op, a);
    chk("model_sel", sel, sel_lit);
    chk("model_val", m_is_st(op) ? m_mdata(op, r2) : ldv, val_lit);
    tick();
    aluop_i = op; mem_addr_i = a; reg2_i = r2; wd_i = 5'd9; wreg_i = 1'b1;
    wdata_i = 32'h0BAD_0000; bus.mem_ack_i = stray; bus.mem_data_i = ~rd;
    e = '{default: 0};
    e.v = 1; e.wd = 5'd9; e.stall = 1;
    if (!mis) begin
      for (int i = 0; i <= waits; i++) begin
        tick();
        bus.mem_ack_i = (i == waits);
        bus.mem_data_i = (i == waits) ? rd : ~rd;
        e.ce = 1; e.we = m_is_st(op); e.sel = sel;
        e.c_addr = 1; e.addr = {a[31:2], 2'b00};
        e.c_mdata = m_is_st(op); e.mdata = m_mdata(op, r2);
      end
    end
    tick();
    bus.mem_ack_i = stray; bus.mem_data_i = 32'h0;
    e.ce = 0; e.we = 0; e.sel = 4'b0000; e.stall = 0; e.c_addr = 0; e.c_mdata = 0;
    e.wreg = m_is_ld(op) && !mis; e.c_wdata = m_is_ld(op) && !mis;
    e.wdata = ldv; e.err = mis;
  endtask

  task automatic run_timeout(aluop_t op, reg_t a);
    tick();
    aluop_i = op; mem_addr_i = a; wd_i = 5'd11; wreg_i = 1'b1;
    bus.mem_ack_i = 1'b0;
    e = '{default: 0};
    e.v = 1; e.wd = 5'd11; e.stall = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      e.ce = 1; e.sel = 4'b1111; e.c_addr = 1; e.addr = {a[31:2], 2'b00};
    end
    tick();
    e.ce = 0; e.sel = 4'b0000; e.c_addr = 0; e.stall = 0; e.wreg = 0; e.err = 1;
  endtask

  task automatic run_reset_in_req();
    tick();
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_0600; wd_i = 5'd6; wreg_i = 1'b1;
    bus.mem_ack_i = 1'b0;
    e = '{default: 0};
    e.v = 1; e.wd = 5'd6; e.stall = 1;
    tick();
    e.ce = 1; e.sel = 4'b1111; e.c_addr = 1; e.addr = 32'h0000_0600;
    tick();
    rst = 1'b0; aluop_i = EXE_NOP_OP; wdata_i = 32'h77;
    e.wd = 5'd0; e.stall = 0; e.c_wdata = 1; e.wdata = 32'h0;
    tick();
    e.ce = 0; e.sel = 4'b0000; e.addr = 32'h0; e.c_mdata = 1; e.mdata = 32'h0;
    tick();
    rst = 1'b1; bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'hFFFF_FFFF;
    set_pass();
    tick();
    bus.mem_ack_i = 1'b0;
    set_pass();
  endtask

  initial begin
    e = '{default: 0};
    rst = 1'b0; aluop_i = EXE_LW_OP; wd_i = 5'd3; wreg_i = 1'b1;
    wdata_i = 32'h5; mem_addr_i = 32'h104; reg2_i = 32'h1111_2222;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      e.v = 1; e.wd = 5'd0; e.wreg = 0; e.c_wdata = 1; e.wdata = 32'h0;
      e.stall = 0; e.ce = 0; e.we = 0; e.sel = 4'b0000; e.err = 0;
      e.c_addr = 1; e.addr = 32'h0; e.c_mdata = 1; e.mdata = 32'h0;
    end
    pass_op(EXE_OR_OP, 5'd4, 1'b1, 32'h0000_1234);
    pass_op(8'b0010_0000, 5'd17, 1'b0, 32'hFFFF_0000);
    pass_op(EXE_NOP_OP, 5'd0, 1'b1, 32'h0);
    run_mem(EXE_LW_OP,  32'h100, 32'h0,         32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    run_mem(EXE_LB_OP,  32'h103, 32'h0,         32'h0000_00F0, 0, 4'b0001, 32'hFFFF_FFF0, 1'b0);
    run_mem(EXE_LBU_OP, 32'h103, 32'h0,         32'h0000_00F0, 0, 4'b0001, 32'h0000_00F0, 1'b0);
    run_timeout(EXE_LW_OP, 32'h500);
    run_mem(EXE_SH_OP,  32'h202, 32'h1234_ABCD, 32'h0,         3, 4'b0011, 32'hABCD_ABCD, 1'b0);
    run_mem(EXE_LH_OP,  32'h102, 32'h0,         32'h1234_8001, 1, 4'b0011, 32'hFFFF_8001, 1'b0);
    run_mem(EXE_LHU_OP, 32'h100, 32'h0,         32'h8001_1234, 0, 4'b1100, 32'h0000_8001, 1'b0);
    run_mem(EXE_SB_OP,  32'h301, 32'h0000_00A5, 32'h0,         1, 4'b0100, 32'hA5A5_A5A5, 1'b1);
    run_mem(EXE_SW_OP,  32'h404, 32'hCAFE_F00D, 32'h0,         2, 4'b1111, 32'hCAFE_F00D, 1'b1);
    run_mem(EXE_LB_OP,  32'h101, 32'h0,         32'h007F_0000, 0, 4'b0100, 32'h0000_007F, 1'b0);
    run_mem(EXE_LH_OP,  32'h103, 32'h0,         32'h0000_FFFE, 0, 4'b0011, 32'hFFFF_FFFE, 1'b0);
    run_mem(EXE_LW_OP,  32'h101, 32'h0,         32'h1122_3344, 0, 4'b1111, 32'h1122_3344, 1'b0);
    run_reset_in_req();
    pass_op(EXE_OR_OP, 5'd21, 1'b1, 32'h0000_4321);
    tick();
    e.v = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
